// File: rtl/sc8_llr_scheduler_pkg.sv
// Shared constants and types for the N=8 SC decoder front end.
// LLRs are sign-magnitude: MSB is the sign (1 = negative), low bits the magnitude.
package sc8_llr_scheduler_pkg;

    localparam int LLR_W = 8;
    localparam int MAG_W = LLR_W - 1;
    localparam int N     = 8;
    localparam logic [MAG_W-1:0] MAG_MAX = 7'd127;

    typedef logic [LLR_W-1:0] llr_t;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_F3,
        ST_F2A,
        ST_LEAF0,
        ST_G2A,
        ST_LEAF1,
        ST_G3,
        ST_F2B,
        ST_LEAF2,
        ST_G2B,
        ST_LEAF3,
        ST_DONE
    } state_t;

endpackage

// File: rtl/sc8_llr_scheduler_if.sv
// Handshake and P-node bus of the SC scheduler. The scheduler is the slave;
// the block feeder / P node / consumer side is the master.
interface sc8_llr_scheduler_if;
    import sc8_llr_scheduler_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [N*LLR_W-1:0] llr_in;
    logic [N-1:0]     frozen_mask;
    llr_t             pair_llr_c;
    llr_t             pair_llr_d;
    logic             pair_frozen1;
    logic             pair_frozen2;
    logic             pair_valid;
    logic             dec_first;
    logic             dec_second;
    logic [N-1:0]     u_hat;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output in_valid, llr_in, frozen_mask, dec_first, dec_second, out_ready,
        input  in_ready, pair_llr_c, pair_llr_d, pair_frozen1, pair_frozen2,
               pair_valid, u_hat, out_valid
    );

    modport slave (
        input  in_valid, llr_in, frozen_mask, dec_first, dec_second, out_ready,
        output in_ready, pair_llr_c, pair_llr_d, pair_frozen1, pair_frozen2,
               pair_valid, u_hat, out_valid
    );

endinterface

// File: rtl/sc8_llr_scheduler_fg_unit.sv
// Combinational f (min-sum) and g (partial-sum corrected add) on one
// sign-magnitude LLR pair; the g result saturates and never yields -0.
module llr_fg_unit
    import sc8_llr_scheduler_pkg::*;
(
    input  llr_t x,
    input  llr_t y,
    input  logic b,
    output llr_t f_out,
    output llr_t g_out
);

    logic             sx;
    logic             sy;
    logic [MAG_W-1:0] mx;
    logic [MAG_W-1:0] my;
    logic [MAG_W:0]   mag_sum;
    logic [MAG_W-1:0] g_mag;
    logic             g_sign;

    assign sx = x[LLR_W-1] ^ b;
    assign sy = y[LLR_W-1];
    assign mx = x[MAG_W-1:0];
    assign my = y[MAG_W-1:0];
    assign mag_sum = {1'b0, mx} + {1'b0, my};

    assign f_out = {x[LLR_W-1] ^ sy, (mx < my) ? mx : my};

    always_comb begin
        g_sign = sy;
        g_mag  = '0;
        if (sx == sy) begin
            g_sign = sy;
            g_mag  = mag_sum[MAG_W] ? MAG_MAX : mag_sum[MAG_W-1:0];
        end else if (mx >= my) begin
            g_sign = sx;
            g_mag  = mx - my;
        end else begin
            g_sign = sy;
            g_mag  = my - mx;
        end
        // A cancelled sum is reported as +0 so downstream hard decisions see 0.
        if (g_mag == '0) begin
            g_sign = 1'b0;
        end
        g_out = {g_sign, g_mag};
    end

endmodule

// File: rtl/sc8_llr_scheduler.sv
// Sequential SC front end for an N=8 polar decoder: stage-3/stage-2 f/g
// updates, four leaf pairs handed to the external P node, u_hat returned.
module sc8_llr_scheduler
    import sc8_llr_scheduler_pkg::*;
(
    input  logic clk,
    input  logic rst,
    sc8_llr_scheduler_if.slave bus
);

    state_t       state_reg;
    llr_t         a_reg [N];
    llr_t         l_reg [4];
    llr_t         p_reg [2];
    logic [3:0]   x_reg;
    logic [N-1:0] u_reg;
    logic [N-1:0] mask_reg;
    logic         pair_valid_reg;
    logic         pair_frozen1_reg;
    logic         pair_frozen2_reg;
    logic         out_valid_reg;

    llr_t fg_x [4];
    llr_t fg_y [4];
    logic fg_b [4];
    llr_t f_res [4];
    llr_t g_res [4];
    logic stage2;
    logic left_half;

    assign stage2 = (state_reg == ST_F2A) || (state_reg == ST_G2A) ||
                    (state_reg == ST_F2B) || (state_reg == ST_G2B);
    assign left_half = (state_reg == ST_F2A) || (state_reg == ST_G2A);

    // Stage 3 uses all four units on (a[i], a[i+4]); stage 2 borrows units 0 and 1.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            fg_x[i] = a_reg[i];
            fg_y[i] = a_reg[i+4];
            fg_b[i] = x_reg[i];
        end
        if (stage2) begin
            fg_x[0] = l_reg[0];
            fg_y[0] = l_reg[2];
            fg_x[1] = l_reg[1];
            fg_y[1] = l_reg[3];
            fg_b[0] = left_half ? (u_reg[0] ^ u_reg[1]) : (u_reg[4] ^ u_reg[5]);
            fg_b[1] = left_half ? u_reg[1] : u_reg[5];
        end
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_fg
            llr_fg_unit u_fg (
                .x     (fg_x[gi]),
                .y     (fg_y[gi]),
                .b     (fg_b[gi]),
                .f_out (f_res[gi]),
                .g_out (g_res[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg        <= ST_IDLE;
            for (int i = 0; i < N; i++) a_reg[i] <= '0;
            for (int i = 0; i < 4; i++) l_reg[i] <= '0;
            p_reg[0]         <= '0;
            p_reg[1]         <= '0;
            x_reg            <= '0;
            u_reg            <= '0;
            mask_reg         <= '0;
            pair_valid_reg   <= 1'b0;
            pair_frozen1_reg <= 1'b0;
            pair_frozen2_reg <= 1'b0;
            out_valid_reg    <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        for (int i = 0; i < N; i++) a_reg[i] <= bus.llr_in[LLR_W*i +: LLR_W];
                        mask_reg  <= bus.frozen_mask;
                        u_reg     <= '0;
                        x_reg     <= '0;
                        state_reg <= ST_F3;
                    end
                end
                ST_F3: begin
                    for (int i = 0; i < 4; i++) l_reg[i] <= f_res[i];
                    state_reg <= ST_F2A;
                end
                ST_F2A, ST_F2B: begin
                    p_reg[0]         <= f_res[0];
                    p_reg[1]         <= f_res[1];
                    pair_valid_reg   <= 1'b1;
                    pair_frozen1_reg <= left_half ? mask_reg[0] : mask_reg[4];
                    pair_frozen2_reg <= left_half ? mask_reg[1] : mask_reg[5];
                    state_reg        <= left_half ? ST_LEAF0 : ST_LEAF2;
                end
                ST_G2A, ST_G2B: begin
                    p_reg[0]         <= g_res[0];
                    p_reg[1]         <= g_res[1];
                    pair_valid_reg   <= 1'b1;
                    pair_frozen1_reg <= left_half ? mask_reg[2] : mask_reg[6];
                    pair_frozen2_reg <= left_half ? mask_reg[3] : mask_reg[7];
                    state_reg        <= left_half ? ST_LEAF1 : ST_LEAF3;
                end
                ST_LEAF0: begin
                    u_reg[0]       <= bus.dec_first;
                    u_reg[1]       <= bus.dec_second;
                    pair_valid_reg <= 1'b0;
                    state_reg      <= ST_G2A;
                end
                ST_LEAF1: begin
                    u_reg[2]       <= bus.dec_first;
                    u_reg[3]       <= bus.dec_second;
                    // Partial sums of the left half: encode4(u0..u3).
                    x_reg          <= {bus.dec_second,
                                       bus.dec_first ^ bus.dec_second,
                                       u_reg[1] ^ bus.dec_second,
                                       u_reg[0] ^ u_reg[1] ^ bus.dec_first ^ bus.dec_second};
                    pair_valid_reg <= 1'b0;
                    state_reg      <= ST_G3;
                end
                ST_G3: begin
                    for (int i = 0; i < 4; i++) l_reg[i] <= g_res[i];
                    state_reg <= ST_F2B;
                end
                ST_LEAF2: begin
                    u_reg[4]       <= bus.dec_first;
                    u_reg[5]       <= bus.dec_second;
                    pair_valid_reg <= 1'b0;
                    state_reg      <= ST_G2B;
                end
                ST_LEAF3: begin
                    u_reg[6]       <= bus.dec_first;
                    u_reg[7]       <= bus.dec_second;
                    pair_valid_reg <= 1'b0;
                    out_valid_reg  <= 1'b1;
                    state_reg      <= ST_DONE;
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        out_valid_reg <= 1'b0;
                        state_reg     <= ST_IDLE;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready     = (state_reg == ST_IDLE);
    assign bus.pair_llr_c   = p_reg[0];
    assign bus.pair_llr_d   = p_reg[1];
    assign bus.pair_frozen1 = pair_frozen1_reg;
    assign bus.pair_frozen2 = pair_frozen2_reg;
    assign bus.pair_valid   = pair_valid_reg;
    assign bus.u_hat        = u_reg;
    assign bus.out_valid    = out_valid_reg;

endmodule
